sys_array_feeder: RTL and testbench

- Transmit-side companion to the systolic array's data port.
- Buffers one ARRAY_A_W x ARRAY_A_L data matrix, written element by element.
- On start, streams the matrix into the array's per-row input_data lanes with diagonal skew: lane r is delayed r cycles.
- Pads with zeros, then holds the lanes at zero for a drain period so the array can flush. Signals busy/done to the controlling FSM.

---
 rtl/sys_array_feeder.sv | 141 ++++++++++++++
 tb/tb_sys_array_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_array_feeder.sv
// ============================================================================
// Module   : sys_array_feeder
// Purpose  : Buffers one ARRAY_A_W x ARRAY_A_L matrix and streams it into the
//            systolic array with diagonal skew, then drains with zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_array_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_A_W    = 4,
    parameter int ARRAY_A_L    = 4,
    parameter int DRAIN_CYCLES = 4,
    localparam int ROW_W = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1,
    localparam int COL_W = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_en,
    input  logic [ROW_W-1:0]                       wr_row,
    input  logic [COL_W-1:0]                       wr_col,
    input  logic [DATA_WIDTH-1:0]                  wr_data,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   data_valid,
    output logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]   input_data
);

    localparam int C_STEPS  = ARRAY_A_W + ARRAY_A_L - 1;
    localparam int C_STEP_W = $clog2(C_STEPS + 1);
    localparam int C_DRN_W  = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                                 r_state;
    logic [C_STEP_W-1:0]                    r_step;
    logic [C_DRN_W-1:0]                     r_drain;
    logic                                   r_busy;
    logic                                   r_done;
    logic                                   r_valid;
    logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]                  r_mem [ARRAY_A_W][ARRAY_A_L];

    logic                                   w_wr_ok;
    logic                                   w_bypass;
    logic [C_STEP_W-1:0]                    w_off;
    logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]   w_vec;
    logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]   w_step0;

    assign w_wr_ok = wr_en && (r_state == IDLE)
                  && ({1'b0, wr_row} < (ROW_W + 1)'(ARRAY_A_W))
                  && ({1'b0, wr_col} < (COL_W + 1)'(ARRAY_A_L));

    // A write landing on A[0][0] in the start edge must reach lane 0 at step 0.
    assign w_bypass = w_wr_ok && (wr_row == '0) && (wr_col == '0);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        w_step0    = '0;
        w_step0[0] = w_bypass ? wr_data : r_mem[0][0];
    end

    // Lane r at step t carries column t-r when that column exists.
    always_comb begin
        w_vec = '0;
        w_off = '0;
        for (int r = 0; r < ARRAY_A_W; r++) begin
            w_off = r_step - C_STEP_W'(r);
            if ((r_step >= C_STEP_W'(r)) && (w_off < C_STEP_W'(ARRAY_A_L))) begin
                w_vec[r] = r_mem[r][w_off[COL_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data  <= w_step0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_step  <= C_STEP_W'(1);
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (r_step == C_STEP_W'(C_STEPS)) begin
                        r_data  <= '0;
                        r_valid <= 1'b0;
                        r_drain <= C_DRN_W'(1);
                        r_state <= DRAIN;
                    end else begin
                        r_data <= w_vec;
                        r_step <= r_step + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain == C_DRN_W'(DRAIN_CYCLES)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_step  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign data_valid = r_valid;
    assign input_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_sys_array_feeder.sv
// ============================================================================
// Module   : tb_sys_array_feeder
// Purpose  : Self-checking bench for sys_array_feeder (4x4x4 and 2x5x1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_array_feeder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            wrA, stA, busyA, doneA, vA;
    logic [1:0]      rowA, colA;
    logic [7:0]      datA;
    logic [0:3][7:0] dA;

    logic            wrB, stB, busyB, doneB, vB;
    logic [0:0]      rowB;
    logic [2:0]      colB;
    logic [7:0]      datB;
    logic [0:1][7:0] dB;

    sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_A_W(4), .ARRAY_A_L(4), .DRAIN_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .wr_en(wrA), .wr_row(rowA), .wr_col(colA),
        .wr_data(datA), .start(stA), .busy(busyA), .done(doneA),
        .data_valid(vA), .input_data(dA)
    );

    sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_A_W(2), .ARRAY_A_L(5), .DRAIN_CYCLES(1)) u_b (
        .clk(clk), .reset(reset), .wr_en(wrB), .wr_row(rowB), .wr_col(colB),
        .wr_data(datB), .start(stB), .busy(busyB), .done(doneB),
        .data_valid(vB), .input_data(dB)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mdl [2][4][5];

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        valid;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tbl [8];

    function automatic int dim_w(int sel); return (sel != 0) ? 2 : 4; endfunction
    function automatic int dim_l(int sel); return (sel != 0) ? 5 : 4; endfunction
    function automatic int dim_d(int sel); return (sel != 0) ? 1 : 4; endfunction

    // Expected lane vector at skew step t, lane 0 in the most significant byte.
    function automatic logic [31:0] exp_vec(int sel, int t);
        logic [31:0] e;
        int c;
        e = '0;
        for (int r = 0; r < dim_w(sel); r++) begin
            c = t - r;
            e = e << 8;
            if (c >= 0 && c < dim_l(sel)) e[7:0] = mdl[sel][r][c];
        end
        return e;
    endfunction

    function automatic logic [31:0] cur_vec(int sel);
        return (sel != 0) ? {16'h0, dB} : dA;
    endfunction
    function automatic logic cur_busy(int sel);  return (sel != 0) ? busyB : busyA; endfunction
    function automatic logic cur_done(int sel);  return (sel != 0) ? doneB : doneA; endfunction
    function automatic logic cur_valid(int sel); return (sel != 0) ? vB : vA;       endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic we, input int r, input int c,
                         input logic [7:0] v, input logic st);
        if (sel == 0) begin
            wrA = we; rowA = 2'(r); colA = 2'(c); datA = v; stA = st;
        end else begin
            wrB = we; rowB = 1'(r); colB = 3'(c); datB = v; stB = st;
        end
    endtask

    task automatic wr(input int sel, input int r, input int c, input logic [7:0] v);
        drive(sel, 1'b1, r, c, v, 1'b0);
        tick();
        drive(sel, 1'b0, 0, 0, 8'h00, 1'b0);
        if (r < dim_w(sel) && c < dim_l(sel)) mdl[sel][r][c] = v;
    endtask

    task automatic check_idle(input int sel, input string nm);
        check({nm, " busy"},  64'(cur_busy(sel)),  64'd0);
        check({nm, " done"},  64'(cur_done(sel)),  64'd0);
        check({nm, " valid"}, 64'(cur_valid(sel)), 64'd0);
        check({nm, " data"},  64'(cur_vec(sel)),   64'd0);
    endtask

    // One full run checked cycle by cycle; inj>0 pokes a write of FF to A[0][0]
    // plus a start pulse during cycle inj, which the busy DUT must ignore.
    task automatic run(input int sel, input int inj, input bit simul, input logic [7:0] sv);
        int s, d, nb, nv;
        logic [31:0] ev;
        s = dim_w(sel) + dim_l(sel) - 1;
        d = dim_d(sel);
        if (simul) begin
            drive(sel, 1'b1, 0, 0, sv, 1'b1);
            mdl[sel][0][0] = sv;
        end else begin
            drive(sel, 1'b0, 0, 0, 8'h00, 1'b1);
        end
        tick();
        drive(sel, 1'b0, 0, 0, 8'h00, 1'b0);
        nb = 0;
        nv = 0;
        for (int k = 1; k <= s + d + 2; k++) begin
            ev = (k <= s) ? exp_vec(sel, k - 1) : 32'h0;
            check($sformatf("run%0d valid k=%0d", sel, k), 64'(cur_valid(sel)), 64'(k <= s));
            check($sformatf("run%0d busy k=%0d", sel, k),  64'(cur_busy(sel)),  64'(k <= s + d));
            check($sformatf("run%0d done k=%0d", sel, k),  64'(cur_done(sel)),  64'(k == s + d + 1));
            check($sformatf("run%0d data k=%0d", sel, k),  64'(cur_vec(sel)),   64'(ev));
            nb += int'(cur_busy(sel));
            nv += int'(cur_valid(sel));
            if (k == inj) drive(sel, 1'b1, 0, 0, 8'hFF, 1'b1);
            tick();
            drive(sel, 1'b0, 0, 0, 8'h00, 1'b0);
        end
        check($sformatf("run%0d busy cycles", sel),  64'(nb), 64'(s + d));
        check($sformatf("run%0d valid cycles", sel), 64'(nv), 64'(s));
    endtask

    initial begin
        int nb, g;
        reset = 1'b1;
        drive(0, 1'b0, 0, 0, 8'h00, 1'b1);
        drive(1, 1'b0, 0, 0, 8'h00, 1'b1);

        // Reset held with start high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle(0, "rstA");
            check_idle(1, "rstB");
        end
        reset = 1'b0;
        drive(0, 1'b0, 0, 0, 8'h00, 1'b0);
        drive(1, 1'b0, 0, 0, 8'h00, 1'b0);
        tick();
        check_idle(0, "post-rst");

        // Known pattern 16r+c+1 and table-driven trace.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(0, r, c, 8'(16 * r + c + 1));
        tbl[0] = '{1,  32'h01000000, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{2,  32'h02110000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{4,  32'h04132231, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{7,  32'h00000034, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8,  32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{11, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{12, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{13, 32'h00000000, 1'b0, 1'b0, 1'b0};
        drive(0, 1'b0, 0, 0, 8'h00, 1'b1);
        tick();
        drive(0, 1'b0, 0, 0, 8'h00, 1'b0);
        nb = 0;
        for (int k = 1; k <= 13; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (tbl[j].cyc == k) begin
                    check($sformatf("tbl data +%0d", k),  64'(dA),    64'(tbl[j].data));
                    check($sformatf("tbl valid +%0d", k), 64'(vA),    64'(tbl[j].valid));
                    check($sformatf("tbl busy +%0d", k),  64'(busyA), 64'(tbl[j].busy));
                    check($sformatf("tbl done +%0d", k),  64'(doneA), 64'(tbl[j].done));
                end
            end
            nb += int'(busyA);
            tick();
        end
        check("tbl busy cycles", 64'(nb), 64'd11);

        // Busy lockout, then a clean run must still show 01 on lane 0.
        run(0, 3, 1'b0, 8'h00);
        run(0, 0, 1'b0, 8'h00);
        // Write and start in the same edge.
        run(0, 0, 1'b1, 8'hAA);

        // Reset at skew step 3, then replay with buffer intact.
        drive(0, 1'b0, 0, 0, 8'h00, 1'b1);
        tick();
        drive(0, 1'b0, 0, 0, 8'h00, 1'b0);
        tick(); tick(); tick();
        check("midrst step3", 64'(dA), 64'(exp_vec(0, 3)));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle(0, "midrst");
        for (int i = 0; i < 12; i++) begin
            check("midrst no done", 64'(doneA), 64'd0);
            check("midrst no busy", 64'(busyA), 64'd0);
            tick();
        end
        run(0, 0, 1'b0, 8'h00);

        // Start held high through done: one idle gap, then a new run.
        drive(0, 1'b0, 0, 0, 8'h00, 1'b1);
        tick();
        g = 0;
        while (!doneA && g < 40) begin
            tick();
            g++;
        end
        check("b2b done seen", 64'(doneA), 64'd1);
        check("b2b gap busy",  64'(busyA), 64'd0);
        tick();
        check("b2b restart busy",  64'(busyA), 64'd1);
        check("b2b restart valid", 64'(vA),    64'd1);
        check("b2b restart data",  64'(dA),    64'(exp_vec(0, 0)));
        drive(0, 1'b0, 0, 0, 8'h00, 1'b0);
        g = 0;
        while (!doneA && g < 40) begin
            tick();
            g++;
        end
        check("b2b second done", 64'(doneA), 64'd1);
        tick();
        check_idle(0, "b2b end");

        // Randomised runs on the 4x4 build.
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    wr(0, r, c, 8'($urandom));
            run(0, int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // 2x5 build with a single drain cycle; includes out-of-range column writes.
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 5; c++)
                    wr(1, r, c, 8'($urandom));
            wr(1, it & 1, 5 + it, 8'($urandom));
            run(1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
